dma_tdd_sync_rx: RTL and testbench

DMA_TDD_SYNC_RX -- requirements
Module: dma_tdd_sync_rx

---
 rtl/sync_bits_2ff.sv | 23 ++
 rtl/dma_tdd_sync_rx.sv | 126 ++++++++++++
 tb/tb_dma_tdd_sync_rx.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sync_bits_2ff.sv
// Two-stage metastability synchronizer for a single asynchronous bit.
// Both stages clear asynchronously so the bit reads 0 right after reset.
module sync_bits_2ff (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;
endmodule

// File: rtl/dma_tdd_sync_rx.sv
// TDD sync pulse receiver: synchronizes a stretched pulse, measures its width
// and reports a strobe for in-tolerance pulses or a short/long error otherwise.
module dma_tdd_sync_rx #(
    parameter int PULSE_WIDTH = 100000,
    parameter int TOLERANCE   = 1000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        sync_pulse_in,
    output logic        sync_strobe,
    output logic [15:0] sync_count,
    output logic [31:0] width_last,
    output logic        err_short,
    output logic        err_long,
    output logic        busy
);
    localparam logic [31:0] MIN_W = 32'(PULSE_WIDTH - TOLERANCE);
    localparam logic [31:0] MAX_W = 32'(PULSE_WIDTH + TOLERANCE);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MEASURE  = 2'd1;
    localparam logic [1:0] S_WAIT_LOW = 2'd2;

    localparam logic [1:0] EV_NONE  = 2'd0;
    localparam logic [1:0] EV_OK    = 2'd1;
    localparam logic [1:0] EV_SHORT = 2'd2;
    localparam logic [1:0] EV_LONG  = 2'd3;

    logic        s_sync;
    logic        r_sync_d;
    logic [1:0]  r_warm;
    logic        r_armed;
    logic [1:0]  r_state, w_state_nx;
    logic [31:0] r_cnt, w_cnt_nx;
    logic [31:0] r_width, w_width_nx;
    logic [1:0]  r_evt, w_evt_nx;
    logic        r_strobe, r_err_short, r_err_long;
    logic [15:0] r_sync_count;
    logic        w_sync_valid;
    logic        w_rise;

    sync_bits_2ff u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (sync_pulse_in),
        .q    (s_sync)
    );

    // The synchronizer only carries real input samples two cycles after reset;
    // arming on a confirmed low keeps a pulse in flight at reset from counting.
    assign w_sync_valid = (r_warm == 2'd2);
    assign w_rise       = s_sync & ~r_sync_d & r_armed;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_width_nx = r_width;
        w_evt_nx   = EV_NONE;
        if (!enable) begin
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        w_state_nx = S_MEASURE;
                        w_cnt_nx   = 32'd1;
                    end
                end
                S_MEASURE: begin
                    if (!s_sync) begin
                        w_state_nx = S_IDLE;
                        w_width_nx = r_cnt;
                        w_evt_nx   = (r_cnt >= MIN_W && r_cnt <= MAX_W) ? EV_OK : EV_SHORT;
                    end else if (r_cnt >= MAX_W) begin
                        w_state_nx = S_WAIT_LOW;
                        w_width_nx = MAX_W + 32'd1;
                        w_evt_nx   = EV_LONG;
                    end else begin
                        w_cnt_nx = r_cnt + 32'd1;
                    end
                end
                S_WAIT_LOW: begin
                    if (!s_sync) w_state_nx = S_IDLE;
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync_d     <= 1'b0;
            r_warm       <= 2'd0;
            r_armed      <= 1'b0;
            r_state      <= S_IDLE;
            r_cnt        <= 32'd0;
            r_width      <= 32'd0;
            r_evt        <= EV_NONE;
            r_strobe     <= 1'b0;
            r_err_short  <= 1'b0;
            r_err_long   <= 1'b0;
            r_sync_count <= 16'd0;
        end else begin
            r_sync_d <= s_sync;
            if (!w_sync_valid) r_warm <= r_warm + 2'd1;
            r_armed  <= r_armed | (w_sync_valid & ~s_sync);
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_width  <= w_width_nx;
            r_evt    <= w_evt_nx;
            // Output register stage: one cycle after the FSM decision.
            r_strobe    <= (r_evt == EV_OK);
            r_err_short <= (r_evt == EV_SHORT);
            r_err_long  <= (r_evt == EV_LONG);
            if (r_evt == EV_OK) r_sync_count <= r_sync_count + 16'd1;
        end
    end

    assign sync_strobe = r_strobe;
    assign err_short   = r_err_short;
    assign err_long    = r_err_long;
    assign sync_count  = r_sync_count;
    assign width_last  = r_width;
    assign busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_dma_tdd_sync_rx.sv
// Directed bench for dma_tdd_sync_rx with PULSE_WIDTH=100, TOLERANCE=10
// (valid widths 90..110, long error reports width 111).
module tb_dma_tdd_sync_rx;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        sync_pulse_in = 1'b0;
    logic        sync_strobe, err_short, err_long, busy;
    logic [15:0] sync_count;
    logic [31:0] width_last;

    int n_cmp = 0;
    int n_bad = 0;
    int n_str = 0;
    int n_es  = 0;
    int n_el  = 0;
    int n_ovl = 0;

    dma_tdd_sync_rx #(.PULSE_WIDTH(100), .TOLERANCE(10)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .enable        (enable),
        .sync_pulse_in (sync_pulse_in),
        .sync_strobe   (sync_strobe),
        .sync_count    (sync_count),
        .width_last    (width_last),
        .err_short     (err_short),
        .err_long      (err_long),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sync_strobe) n_str <= n_str + 1;
        if (err_short)   n_es  <= n_es + 1;
        if (err_long)    n_el  <= n_el + 1;
        if ((int'(sync_strobe) + int'(err_short) + int'(err_long)) > 1) n_ovl <= n_ovl + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int n);
        sync_pulse_in = 1'b1;
        tick(n);
        sync_pulse_in = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; enable = 1'b0;
        tick(2);
        n_cmp++; if (sync_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe got %b want 0", sync_strobe); end
        n_cmp++; if (err_short !== 1'b0) begin n_bad++; $display("FAIL reset_err_short got %b want 0", err_short); end
        n_cmp++; if (err_long !== 1'b0) begin n_bad++; $display("FAIL reset_err_long got %b want 0", err_long); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (sync_count !== 16'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", sync_count); end
        n_cmp++; if (width_last !== 32'd0) begin n_bad++; $display("FAIL reset_width got %0d want 0", width_last); end
        rstn = 1'b1; enable = 1'b1;
        tick(4);
    endtask

    task automatic test_valid_pulse();
        int s0;
        s0 = n_str;
        sync_pulse_in = 1'b1;
        tick(50);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL valid_busy_mid got %b want 1", busy); end
        tick(50);
        sync_pulse_in = 1'b0;
        tick(3);
        n_cmp++; if (sync_strobe !== 1'b0) begin n_bad++; $display("FAIL valid_early_strobe got %b want 0", sync_strobe); end
        n_cmp++; if (width_last !== 32'd100) begin n_bad++; $display("FAIL valid_width got %0d want 100", width_last); end
        tick(1);
        n_cmp++; if (sync_strobe !== 1'b1) begin n_bad++; $display("FAIL valid_strobe_lat4 got %b want 1", sync_strobe); end
        n_cmp++; if (sync_count !== 16'd1) begin n_bad++; $display("FAIL valid_count got %0d want 1", sync_count); end
        tick(1);
        n_cmp++; if (sync_strobe !== 1'b0) begin n_bad++; $display("FAIL valid_strobe_width got %b want 0", sync_strobe); end
        tick(6);
        n_cmp++; if (n_str - s0 !== 1) begin n_bad++; $display("FAIL valid_strobe_total got %0d want 1", n_str - s0); end
    endtask

    task automatic test_width_bounds();
        pulse(89);
        tick(4);
        n_cmp++; if (err_short !== 1'b1) begin n_bad++; $display("FAIL short89_err got %b want 1", err_short); end
        n_cmp++; if (sync_strobe !== 1'b0) begin n_bad++; $display("FAIL short89_strobe got %b want 0", sync_strobe); end
        n_cmp++; if (width_last !== 32'd89) begin n_bad++; $display("FAIL short89_width got %0d want 89", width_last); end
        n_cmp++; if (sync_count !== 16'd1) begin n_bad++; $display("FAIL short89_count got %0d want 1", sync_count); end
        tick(8);
        pulse(90);
        tick(4);
        n_cmp++; if (sync_strobe !== 1'b1) begin n_bad++; $display("FAIL ok90_strobe got %b want 1", sync_strobe); end
        n_cmp++; if (width_last !== 32'd90) begin n_bad++; $display("FAIL ok90_width got %0d want 90", width_last); end
        n_cmp++; if (sync_count !== 16'd2) begin n_bad++; $display("FAIL ok90_count got %0d want 2", sync_count); end
        tick(8);
        pulse(110);
        tick(4);
        n_cmp++; if (sync_strobe !== 1'b1) begin n_bad++; $display("FAIL ok110_strobe got %b want 1", sync_strobe); end
        n_cmp++; if (width_last !== 32'd110) begin n_bad++; $display("FAIL ok110_width got %0d want 110", width_last); end
        n_cmp++; if (sync_count !== 16'd3) begin n_bad++; $display("FAIL ok110_count got %0d want 3", sync_count); end
        tick(8);
    endtask

    task automatic test_long();
        int s0, e0;
        s0 = n_str; e0 = n_el;
        sync_pulse_in = 1'b1;
        tick(113);
        n_cmp++; if (err_long !== 1'b0) begin n_bad++; $display("FAIL long_early got %b want 0", err_long); end
        n_cmp++; if (width_last !== 32'd111) begin n_bad++; $display("FAIL long_width got %0d want 111", width_last); end
        tick(1);
        n_cmp++; if (err_long !== 1'b1) begin n_bad++; $display("FAIL long_err got %b want 1", err_long); end
        tick(86);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL long_busy_high got %b want 1", busy); end
        sync_pulse_in = 1'b0;
        tick(2);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL long_busy_fall got %b want 1", busy); end
        tick(1);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL long_busy_idle got %b want 0", busy); end
        tick(8);
        n_cmp++; if (n_el - e0 !== 1) begin n_bad++; $display("FAIL long_err_total got %0d want 1", n_el - e0); end
        n_cmp++; if (n_str - s0 !== 0) begin n_bad++; $display("FAIL long_strobe_total got %0d want 0", n_str - s0); end
        n_cmp++; if (sync_count !== 16'd3) begin n_bad++; $display("FAIL long_count got %0d want 3", sync_count); end
    endtask

    task automatic test_enable_drop();
        int s0, es0, el0;
        s0 = n_str; es0 = n_es; el0 = n_el;
        sync_pulse_in = 1'b1;
        tick(50);
        enable = 1'b0;
        tick(1);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL en_busy got %b want 0", busy); end
        tick(19);
        enable = 1'b1;
        tick(30);
        sync_pulse_in = 1'b0;
        tick(10);
        n_cmp++; if (n_str - s0 !== 0) begin n_bad++; $display("FAIL en_strobe got %0d want 0", n_str - s0); end
        n_cmp++; if ((n_es - es0) + (n_el - el0) !== 0) begin n_bad++; $display("FAIL en_errors got %0d want 0", (n_es - es0) + (n_el - el0)); end
        n_cmp++; if (sync_count !== 16'd3) begin n_bad++; $display("FAIL en_count got %0d want 3", sync_count); end
        n_cmp++; if (width_last !== 32'd111) begin n_bad++; $display("FAIL en_width got %0d want 111", width_last); end
    endtask

    task automatic test_reset_mid_pulse();
        int s0, es0;
        sync_pulse_in = 1'b1;
        tick(30);
        rstn = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", busy); end
        n_cmp++; if (sync_count !== 16'd0) begin n_bad++; $display("FAIL rmid_count got %0d want 0", sync_count); end
        n_cmp++; if (width_last !== 32'd0) begin n_bad++; $display("FAIL rmid_width got %0d want 0", width_last); end
        tick(2);
        rstn = 1'b1;
        s0 = n_str; es0 = n_es;
        tick(50);
        sync_pulse_in = 1'b0;
        tick(10);
        n_cmp++; if (n_str - s0 !== 0) begin n_bad++; $display("FAIL rmid_strobe got %0d want 0", n_str - s0); end
        n_cmp++; if (n_es - es0 !== 0) begin n_bad++; $display("FAIL rmid_err_short got %0d want 0", n_es - es0); end
        pulse(100);
        tick(4);
        n_cmp++; if (sync_strobe !== 1'b1) begin n_bad++; $display("FAIL rmid_next_strobe got %b want 1", sync_strobe); end
        n_cmp++; if (sync_count !== 16'd1) begin n_bad++; $display("FAIL rmid_next_count got %0d want 1", sync_count); end
        tick(8);
    endtask

    task automatic test_wrap();
        force dut.r_sync_count = 16'hFFFE;
        #1;
        release dut.r_sync_count;
        tick(1);
        pulse(100);
        tick(4);
        n_cmp++; if (sync_count !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_ffff got %h want ffff", sync_count); end
        tick(8);
        pulse(95);
        tick(4);
        n_cmp++; if (sync_strobe !== 1'b1) begin n_bad++; $display("FAIL wrap_strobe got %b want 1", sync_strobe); end
        n_cmp++; if (sync_count !== 16'h0000) begin n_bad++; $display("FAIL wrap_zero got %h want 0000", sync_count); end
        tick(8);
    endtask

    task automatic test_exclusive();
        n_cmp++; if (n_ovl !== 0) begin n_bad++; $display("FAIL exclusive_overlap got %0d want 0", n_ovl); end
    endtask

    initial begin
        test_reset();
        test_valid_pulse();
        test_width_bounds();
        test_long();
        test_enable_drop();
        test_reset_mid_pulse();
        test_wrap();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
